// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register sequencer.
// Holds the mode codes, the FSM state type and the op_count width helper.
package usr_pkg;

  localparam logic [2:0] USR_HOLD = 3'b000;
  localparam logic [2:0] USR_SHR  = 3'b001;
  localparam logic [2:0] USR_SHL  = 3'b010;
  localparam logic [2:0] USR_LOAD = 3'b011;
  localparam logic [2:0] USR_ROR  = 3'b100;
  localparam logic [2:0] USR_ROL  = 3'b101;
  localparam logic [2:0] USR_ASR  = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_e;

  function automatic int usr_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_step_logic.sv
// One-step next value of the shift register for a given mode.
// Rotate modes exist only when USR_ROTATE_EN is defined; otherwise they hold.
module usr_step_logic
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] cur,
  input  logic             serial_in_right,
  input  logic             serial_in_left,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (mode)
      USR_SHR:  nxt = {serial_in_right, cur[WIDTH-1:1]};
      USR_SHL:  nxt = {cur[WIDTH-2:0], serial_in_left};
      USR_LOAD: nxt = load_data;
      USR_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
      USR_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      USR_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
`endif
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/usr_param_sequencer.sv
// Universal shift register with a multi-step operation sequencer (FSM, step counter, register).
// Build option: define USR_ROTATE_EN to enable ROR/ROL; otherwise those modes are no-ops.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | op_ready high; an accepted op latches mode, data and count
// ST_RUN  | one step per clock until the counter reaches terminal count
module usr_param_sequencer
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = usr_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_mode,
  input  logic [CNT_W-1:0] op_count,
  input  logic             serial_in_right,
  input  logic             serial_in_left,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] out,
  output logic             serial_out_right,
  output logic             serial_out_left,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  usr_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] sat_count;
  logic [CNT_W-1:0] eff_count;
  logic [WIDTH-1:0] step_val;

  usr_step_logic #(.WIDTH(WIDTH)) u_step (
    .mode            (mode_q),
    .cur             (out_q),
    .serial_in_right (serial_in_right),
    .serial_in_left  (serial_in_left),
    .load_data       (data_q),
    .nxt             (step_val)
  );

  // Steps to run for the requested op; zero marks a no-op that still completes at T1.
  always_comb begin
    sat_count = (op_count > WIDTH_C) ? WIDTH_C : op_count;
    eff_count = '0;
    case (op_mode)
      USR_SHR, USR_SHL, USR_ASR: eff_count = sat_count;
      USR_LOAD:                  eff_count = ONE_C;
`ifdef USR_ROTATE_EN
      USR_ROR, USR_ROL:          eff_count = sat_count;
`endif
      default:                   eff_count = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      data_q  <= '0;
      mode_q  <= USR_HOLD;
      steps_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      steps_q <= steps_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    data_d  = data_q;
    mode_d  = mode_q;
    steps_d = steps_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          state_d = ST_RUN;
          mode_d  = op_mode;
          data_d  = parallel_in;
          steps_d = eff_count;
        end
      end
      ST_RUN: begin
        if (steps_q != '0) begin
          out_d   = step_val;
          steps_d = steps_q - ONE_C;
        end
        if (steps_q <= ONE_C) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign op_ready         = (state_q == ST_IDLE);
  assign busy             = (state_q == ST_RUN);
  assign done             = done_q;
  assign out              = out_q;
  assign serial_out_right = out_q[0];
  assign serial_out_left  = out_q[WIDTH-1];

endmodule

// File: tb/tb_usr_param_sequencer.sv
// Self-checking bench for usr_param_sequencer (WIDTH=8), directed plus randomized ops.
// Follows USR_ROTATE_EN the same way as the design build.
module tb_usr_param_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_mode;
  logic [CW-1:0] op_count;
  logic          serial_in_right;
  logic          serial_in_left;
  logic [W-1:0]  parallel_in;
  logic [W-1:0]  out;
  logic          serial_out_right;
  logic          serial_out_left;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_out;

  usr_param_sequencer #(.WIDTH(W)) dut (
    .clk              (clk),
    .clear_n          (clear_n),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_mode          (op_mode),
    .op_count         (op_count),
    .serial_in_right  (serial_in_right),
    .serial_in_left   (serial_in_left),
    .parallel_in      (parallel_in),
    .out              (out),
    .serial_out_right (serial_out_right),
    .serial_out_left  (serial_out_left),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rotate_on();
`ifdef USR_ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Number of register-changing steps an op performs.
  function automatic int ref_steps(input logic [2:0] m, input int cnt);
    int c;
    c = (cnt > W) ? W : cnt;
    case (m)
      3'd1, 3'd2, 3'd6: return c;
      3'd3:             return 1;
      3'd4, 3'd5:       return rotate_on() ? c : 0;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_step(input logic [2:0] m, input logic [W-1:0] v,
                                            input logic sir, input logic sil,
                                            input logic [W-1:0] pin);
    case (m)
      3'd1:    return (v >> 1) | (sir ? 8'h80 : 8'h00);
      3'd2:    return (v << 1) | {7'd0, sil};
      3'd3:    return pin;
      3'd4:    return (v >> 1) | (v << 7);
      3'd5:    return (v << 1) | (v >> 7);
      3'd6:    return 8'($signed(v) >>> 1);
      default: return v;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "_out"}, out, m_out);
    check({tag, "_sor"}, {7'd0, serial_out_right}, {7'd0, m_out[0]});
    check({tag, "_sol"}, {7'd0, serial_out_left}, {7'd0, m_out[W-1]});
  endtask

  // Accept an op at the next edge and follow it to completion, checking every cycle.
  task automatic do_op(input string tag, input logic [2:0] m, input int cnt,
                       input logic [W-1:0] pin, input bit rnd,
                       input logic sir_c, input logic sil_c, input bit noisy);
    int n, cyc;
    logic sir, sil;
    n   = ref_steps(m, cnt);
    cyc = (n == 0) ? 1 : n;
    op_valid = 1'b1; op_mode = m; op_count = CW'(cnt); parallel_in = pin;
    check({tag, "_ready"}, {7'd0, op_ready}, 8'd1);
    @(negedge clk);
    op_valid = noisy; op_mode = 3'($urandom); op_count = CW'($urandom);
    parallel_in = W'($urandom);
    check({tag, "_t0_busy"}, {7'd0, busy}, 8'd1);
    check({tag, "_t0_done"}, {7'd0, done}, 8'd0);
    check({tag, "_t0_out"}, out, m_out);
    for (int k = 0; k < cyc; k++) begin
      sir = rnd ? 1'($urandom) : sir_c;
      sil = rnd ? 1'($urandom) : sil_c;
      serial_in_right = sir;
      serial_in_left  = sil;
      if (k < n) m_out = ref_step(m, m_out, sir, sil, pin);
      if (noisy) begin
        op_mode = 3'($urandom); parallel_in = W'($urandom);
      end
      @(negedge clk);
      check_outs({tag, "_step"});
      check({tag, "_busy"}, {7'd0, busy}, {7'd0, (k != cyc - 1)});
      check({tag, "_done"}, {7'd0, done}, {7'd0, (k == cyc - 1)});
      check({tag, "_rdy"}, {7'd0, op_ready}, {7'd0, (k == cyc - 1)});
    end
    op_valid = 1'b0;
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_done"}, {7'd0, done}, 8'd0);
    check({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
    check_outs({tag, "_idle"});
  endtask

  initial begin
    clear_n = 1'b0; op_valid = 1'b0; op_mode = 3'd0; op_count = '0;
    serial_in_right = 1'b0; serial_in_left = 1'b0; parallel_in = '0;
    m_out = '0;
    #12;
    check("rst_out", out, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_ready", {7'd0, op_ready}, 8'd1);
    check("rst_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    clear_n = 1'b1;
    idle("post_rst");

    // LOAD A5, SHR x3 with 1s entering -> F4
    do_op("load_a5", 3'd3, 0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("a5");
    do_op("shr3", 3'd1, 3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("shr3_f4", out, 8'hF4);
    idle("shr3");

    do_op("load_81", 3'd3, 5, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("shl1", 3'd2, 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("shl1_02", out, 8'h02);
    do_op("load_80", 3'd3, 0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("asr2", 3'd6, 2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("asr2_e0", out, 8'hE0);
    idle("asr2");

    do_op("load_81b", 3'd3, 0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("rol8", 3'd5, 8, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rol8_81", out, 8'h81);
    idle("rol8");

    do_op("load_ff", 3'd3, 0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("shr15", 3'd1, 15, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("shr15_00", out, 8'h00);
    do_op("hold", 3'd0, 7, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("rsvd", 3'd7, 4, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    do_op("cnt0", 3'd2, 0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("noops");

    // Reset in the middle of a SHR count 5 aborts it with no done pulse
    do_op("load_3c", 3'd3, 0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    op_valid = 1'b1; op_mode = 3'd1; op_count = 4'd5; serial_in_right = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    m_out = '0;
    check("mid_rst_out", out, 8'h00);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_ready", {7'd0, op_ready}, 8'd1);
    check("mid_rst_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    clear_n = 1'b1;
    idle("after_rst1");
    idle("after_rst2");

    // Randomized ops, back-to-back or with gaps, serial inputs changing per step
    for (int i = 0; i < 60; i++) begin
      do_op("rnd", 3'($urandom), int'($urandom_range(0, 15)), W'($urandom),
            1'b1, 1'b0, 1'b0, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
